drum_sequencer: RTL and testbench

16-step pattern sequencer for the drum synth. Fires tone and noise voice triggers on a tempo grid and applies a per-voice exponential-decay amplitude envelope. Mixes the enveloped tone and noise samples into one 8-bit offset-binary DAC word at a fixed sample rate. Sits between the sine_gen/noise_gen datapaths and the GPIO DAC pins, and owns the shared DAC output.

---
 rtl/drum_pkg.sv | 16 +
 rtl/drum_envelope.sv | 36 +++
 rtl/drum_sequencer.sv | 145 ++++++++++++++
 tb/tb_drum_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and constants for the drum sequencer block.
package drum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      COUNT
   } seq_state_t;

   localparam int unsigned VOICE_TONE  = 0;
   localparam int unsigned VOICE_NOISE = 1;
   localparam logic [7:0]  DAC_MID     = 8'h80;
   localparam logic [7:0]  ENV_MAX     = 8'hFF;
   localparam int unsigned NUM_STEPS   = 16;

endpackage

// File: rtl/drum_envelope.sv
// Per-voice exponential-decay amplitude envelope: trigger loads full scale,
// each sample tick removes env >> DECAY_SHIFT (minimum step of 1).
module drum_envelope
   import drum_pkg::*;
#(
   parameter int unsigned DECAY_SHIFT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trig,
   input  logic       tick,
   output logic [7:0] env
);

   localparam logic [7:0] THRESH = 8'(1 << DECAY_SHIFT);

   logic [7:0] env_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         env_q <= '0;
      end else if (trig) begin
         env_q <= ENV_MAX;
      end else if (tick) begin
         // Below the threshold the shifted term is zero, so fall back to -1.
         if (env_q >= THRESH) begin
            env_q <= env_q - (env_q >> DECAY_SHIFT);
         end else if (env_q != '0) begin
            env_q <= env_q - 8'd1;
         end
      end
   end

   assign env = env_q;

endmodule

// File: rtl/drum_sequencer.sv
// 16-step drum pattern sequencer: fires tone/noise triggers on a tempo grid and
// mixes enveloped voice samples into a saturated offset-binary DAC word.
module drum_sequencer
   import drum_pkg::*;
#(
   parameter int unsigned STEP_DIV    = 6250000,
   parameter int unsigned SAMPLE_DIV  = 1042,
   parameter int unsigned DECAY_SHIFT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       pattern_we,
   input  logic [3:0] pattern_addr,
   input  logic [1:0] pattern_wdata,
   input  logic [7:0] tone_sample,
   input  logic [7:0] noise_sample,
   output logic [3:0] step_idx,
   output logic       tone_trig,
   output logic       noise_trig,
   output logic [7:0] dac_out,
   output logic       sample_valid
);

   localparam int unsigned STEP_CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned SAMP_CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);
   localparam logic [SAMP_CW-1:0] SAMP_LAST = SAMP_CW'(SAMPLE_DIV - 1);

   seq_state_t         state_q;
   logic [3:0]         step_idx_q;
   logic [STEP_CW-1:0] step_cnt_q;
   logic [SAMP_CW-1:0] samp_cnt_q;
   logic [1:0]         pattern_q [NUM_STEPS];
   logic [7:0]         dac_q;
   logic [7:0]         dac_d;
   logic               sample_valid_q;
   logic               tick;
   logic [7:0]         env_tone;
   logic [7:0]         env_noise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         step_idx_q <= '0;
         step_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               step_idx_q <= '0;
               step_cnt_q <= '0;
               if (run) state_q <= FIRE;
            end
            FIRE: begin
               if (!run) begin
                  state_q    <= IDLE;
                  step_idx_q <= '0;
                  step_cnt_q <= '0;
               end else begin
                  state_q    <= COUNT;
                  step_cnt_q <= STEP_CW'(1);
               end
            end
            COUNT: begin
               if (!run) begin
                  state_q    <= IDLE;
                  step_idx_q <= '0;
                  step_cnt_q <= '0;
               end else if (step_cnt_q == STEP_LAST) begin
                  state_q    <= FIRE;
                  step_idx_q <= step_idx_q + 4'd1;
                  step_cnt_q <= '0;
               end else begin
                  step_cnt_q <= step_cnt_q + STEP_CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_STEPS; i++) pattern_q[i] <= '0;
      end else if (pattern_we) begin
         pattern_q[pattern_addr] <= pattern_wdata;
      end
   end

   // Triggers read the pre-edge pattern, so a write landing during FIRE waits a pass.
   assign tone_trig  = (state_q == FIRE) && pattern_q[step_idx_q][VOICE_TONE];
   assign noise_trig = (state_q == FIRE) && pattern_q[step_idx_q][VOICE_NOISE];
   assign tick       = (samp_cnt_q == SAMP_LAST);

   drum_envelope #(.DECAY_SHIFT(DECAY_SHIFT)) u_env_tone (
      .clk   (clk),
      .reset (reset),
      .trig  (tone_trig),
      .tick  (tick),
      .env   (env_tone)
   );

   drum_envelope #(.DECAY_SHIFT(DECAY_SHIFT)) u_env_noise (
      .clk   (clk),
      .reset (reset),
      .trig  (noise_trig),
      .tick  (tick),
      .env   (env_noise)
   );

   logic signed [17:0] s_tone, s_noise, p_tone, p_noise, sum;

   always_comb begin
      s_tone  = $signed({10'd0, tone_sample}) - 18'sd128;
      s_noise = $signed({10'd0, noise_sample}) - 18'sd128;
      p_tone  = s_tone * $signed({10'd0, env_tone});
      p_noise = s_noise * $signed({10'd0, env_noise});
      sum     = (p_tone >>> 8) + (p_noise >>> 8);
      dac_d   = DAC_MID;
      if (sum > 18'sd127) begin
         dac_d = 8'hFF;
      end else if (sum < -18'sd128) begin
         dac_d = 8'h00;
      end else begin
         dac_d = sum[7:0] ^ DAC_MID;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_cnt_q     <= '0;
         dac_q          <= DAC_MID;
         sample_valid_q <= 1'b0;
      end else begin
         samp_cnt_q     <= tick ? '0 : samp_cnt_q + SAMP_CW'(1);
         sample_valid_q <= tick;
         if (tick) dac_q <= dac_d;
      end
   end

   assign step_idx     = step_idx_q;
   assign dac_out      = dac_q;
   assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_drum_sequencer.sv
// Bench for drum_sequencer: cycle-level reference model plus directed vectors.
module tb_drum_sequencer;

   localparam int STEP_DIV    = 8;
   localparam int SAMPLE_DIV  = 4;
   localparam int DECAY_SHIFT = 2;

   logic       clk = 1'b0;
   logic       reset, run, pattern_we;
   logic [3:0] pattern_addr;
   logic [1:0] pattern_wdata;
   logic [7:0] tone_sample, noise_sample;
   logic [3:0] step_idx;
   logic       tone_trig, noise_trig, sample_valid;
   logic [7:0] dac_out;

   always #5 clk = ~clk;

   drum_sequencer #(
      .STEP_DIV    (STEP_DIV),
      .SAMPLE_DIV  (SAMPLE_DIV),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .pattern_we    (pattern_we),
      .pattern_addr  (pattern_addr),
      .pattern_wdata (pattern_wdata),
      .tone_sample   (tone_sample),
      .noise_sample  (noise_sample),
      .step_idx      (step_idx),
      .tone_trig     (tone_trig),
      .noise_trig    (noise_trig),
      .dac_out       (dac_out),
      .sample_valid  (sample_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: playing flag, phase within step (0 = trigger cycle).
   bit m_play;
   int m_phase, m_step, m_scnt, m_dac;
   bit m_sv;
   int m_pat [16];
   int m_env [2];

   typedef struct {
      logic [7:0] ts;
      logic [7:0] ns;
      logic [1:0] hits;
      logic [7:0] exp_dac;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int vmix(int samp, int env);
      int p;
      p = (samp - 128) * env;
      if (p >= 0) return p / 256;
      return -((-p + 255) / 256);
   endfunction

   function automatic int decay(int env);
      int d;
      d = 1 << DECAY_SHIFT;
      if (env >= d) return env - env / d;
      if (env > 0) return env - 1;
      return 0;
   endfunction

   function automatic int exp_trig(int v);
      if (m_play && m_phase == 0) return (m_pat[m_step] >> v) & 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_play = 0; m_phase = 0; m_step = 0; m_scnt = 0; m_dac = 128; m_sv = 0;
      for (int i = 0; i < 16; i++) m_pat[i] = 0;
      m_env[0] = 0; m_env[1] = 0;
   endtask

   task automatic model_step();
      int tr [2];
      int sum;
      bit tk;
      if (reset) begin
         model_reset();
         return;
      end
      tk = (m_scnt == SAMPLE_DIV - 1);
      for (int v = 0; v < 2; v++) tr[v] = exp_trig(v);
      m_sv = tk;
      if (tk) begin
         sum = vmix(int'(tone_sample), m_env[0]) + vmix(int'(noise_sample), m_env[1]);
         if (sum > 127) sum = 127;
         if (sum < -128) sum = -128;
         m_dac = sum + 128;
      end
      for (int v = 0; v < 2; v++) begin
         if (tr[v] != 0) m_env[v] = 255;
         else if (tk) m_env[v] = decay(m_env[v]);
      end
      m_scnt = (m_scnt + 1) % SAMPLE_DIV;
      if (!m_play) begin
         m_step = 0;
         if (run) begin
            m_play  = 1;
            m_phase = 0;
         end
      end else if (!run) begin
         m_play = 0;
         m_step = 0;
      end else begin
         m_phase++;
         if (m_phase == STEP_DIV) begin
            m_phase = 0;
            m_step  = (m_step + 1) % 16;
         end
      end
      if (pattern_we) m_pat[pattern_addr] = int'(pattern_wdata);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("step_idx", int'(step_idx), m_step);
      check("tone_trig", int'(tone_trig), exp_trig(0));
      check("noise_trig", int'(noise_trig), exp_trig(1));
      check("sample_valid", int'(sample_valid), int'(m_sv));
      check("dac_out", int'(dac_out), m_dac);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1; run = 1'b0; pattern_we = 1'b0;
      model_reset();
      for (int i = 0; i < cycles; i++) cyc();
      reset = 1'b0;
   endtask

   task automatic write_pat(input int addr, input int data);
      pattern_we = 1'b1; pattern_addr = 4'(addr); pattern_wdata = 2'(data);
      cyc();
      pattern_we = 1'b0;
   endtask

   task automatic wait_trig(output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (tone_trig || noise_trig) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("trig_timeout", 0, 1);
   endtask

   task automatic wait_sample(output bit ok);
      ok = 0;
      for (int i = 0; i < 4 * SAMPLE_DIV; i++) begin
         cyc();
         if (sample_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("sample_timeout", 0, 1);
   endtask

   initial begin
      bit ok;
      int gap, t_last, t_now, nwrap, cnt, last_dac;
      int prev;
      int dacs [$];
      int exp_decay [5];

      vecs[0] = '{8'hFF, 8'h80, 2'b01, 8'hFE};
      vecs[1] = '{8'hFF, 8'hFF, 2'b11, 8'hFF};
      vecs[2] = '{8'h00, 8'h00, 2'b11, 8'h00};
      vecs[3] = '{8'h80, 8'h80, 2'b11, 8'h80};
      vecs[4] = '{8'h00, 8'h80, 2'b01, 8'h00};
      vecs[5] = '{8'hC0, 8'h40, 2'b11, 8'h7F};
      vecs[6] = '{8'h80, 8'hFF, 2'b10, 8'hFE};
      exp_decay = '{8'hFE, 8'hDF, 8'hC7, 8'hB5, 8'hA8};

      pattern_addr = '0; pattern_wdata = '0;
      tone_sample = 8'h80; noise_sample = 8'h80;
      do_reset(20);

      // Trigger spacing and step wrap period.
      write_pat(0, 1);
      write_pat(2, 2);
      run = 1'b1;
      wait_trig(ok);
      check("first_trig_is_tone", int'(tone_trig), 1);
      gap = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (noise_trig) begin
            gap = i;
            break;
         end
      end
      check("tone_to_noise_gap", gap, 2 * STEP_DIV);
      nwrap = 0; t_last = 0; t_now = 0;
      for (int i = 0; i < 400 && nwrap < 2; i++) begin
         prev = int'(step_idx);
         cyc();
         t_now++;
         if (prev == 15 && step_idx == 4'd0) begin
            if (nwrap == 1) check("wrap_period", t_now - t_last, 16 * STEP_DIV);
            t_last = t_now;
            nwrap++;
         end
      end
      check("wrap_seen_twice", nwrap, 2);

      // Table of mix/saturation vectors at the first tick after a load.
      foreach (vecs[k]) begin
         do_reset(2);
         tone_sample = vecs[k].ts; noise_sample = vecs[k].ns;
         write_pat(0, int'(vecs[k].hits));
         run = 1'b1;
         wait_trig(ok);
         cyc();
         wait_sample(ok);
         check($sformatf("vec%0d_dac", k), int'(dac_out), int'(vecs[k].exp_dac));
         run = 1'b0;
         cyc();
      end

      // Decay sequence, run dropped mid-count while the envelope keeps decaying.
      do_reset(2);
      tone_sample = 8'hFF; noise_sample = 8'h80;
      write_pat(0, 1);
      run = 1'b1;
      wait_trig(ok);
      cyc();
      for (int i = 0; i < 120; i++) begin
         cyc();
         if (i == 2) run = 1'b0;
         if (i == 3) check("idle_step_idx", int'(step_idx), 0);
         if (sample_valid) dacs.push_back(int'(dac_out));
      end
      check("decay_tick_count", (dacs.size() >= 25) ? 1 : 0, 1);
      for (int i = 0; i < 5 && i < dacs.size(); i++)
         check($sformatf("decay%0d", i), dacs[i], exp_decay[i]);
      last_dac = (dacs.size() > 0) ? dacs[dacs.size() - 1] : -1;
      check("decay_to_mid", last_dac, 128);

      // Asynchronous reset in the middle of a decay.
      run = 1'b1;
      wait_trig(ok);
      for (int i = 0; i < 3 * SAMPLE_DIV; i++) cyc();
      check("pre_reset_dac_nonmid", (dac_out != 8'h80) ? 1 : 0, 1);
      reset = 1'b1;
      #1;
      check("async_reset_dac", int'(dac_out), 128);
      check("async_reset_step", int'(step_idx), 0);
      check("async_reset_sv", int'(sample_valid), 0);
      model_reset();
      run = 1'b0;
      cyc();
      reset = 1'b0;
      wait_sample(ok);
      check("post_reset_dac", int'(dac_out), 128);

      // Write to the step currently firing: old value used, new one 16 steps on.
      do_reset(2);
      run = 1'b1;
      cnt = 0;
      while (!(m_play && m_phase == 0 && m_step == 5) && cnt < 300) begin
         cyc();
         cnt++;
      end
      check("reach_step5_fire", (cnt < 300) ? 1 : 0, 1);
      pattern_we = 1'b1; pattern_addr = 4'd5; pattern_wdata = 2'b11;
      check("same_cycle_no_tone", int'(tone_trig), 0);
      cyc();
      pattern_we = 1'b0;
      gap = 1;
      while (!tone_trig && gap < 300) begin
         cyc();
         gap++;
      end
      check("refire_gap", gap, 16 * STEP_DIV);
      check("refire_noise", int'(noise_trig), 1);

      // Randomized traffic against the model.
      do_reset(2);
      run = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) run = ~run;
         pattern_we = ($urandom_range(0, 99) < 10);
         pattern_addr = 4'($urandom_range(0, 15));
         pattern_wdata = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 30) tone_sample = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 99) < 30) noise_sample = 8'($urandom_range(0, 255));
         reset = ($urandom_range(0, 999) < 3);
         cyc();
      end
      reset = 1'b0;
      pattern_we = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
